// File: rtl/fifo_wr_arbiter_if.sv
// Handshake bundle between NREQ producers, the write arbiter and the shared fifo write port.
interface fifo_wr_arbiter_if #(
    parameter int NREQ = 4,
    parameter int OW   = 2,
    parameter int DW   = 16
);
    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] din;
    logic [NREQ-1:0]    gnt;
    logic               fifo_we;
    logic [DW-1:0]      fifo_din;
    logic               fifo_full;
    logic               fifo_almost_full;
    logic               busy;
    logic [OW-1:0]      owner;

    modport master (
        input  req, din, fifo_full, fifo_almost_full,
        output gnt, fifo_we, fifo_din, busy, owner
    );

    modport slave (
        output req, din, fifo_full, fifo_almost_full,
        input  gnt, fifo_we, fifo_din, busy, owner
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-bounded arbiter sharing one fifo write port among NREQ producers.
// Define FIFO_WR_ARB_STAT_EN to add the saturating stall_cnt statistics output.
module fifo_wr_arbiter #(
    parameter int NREQ  = 4,
    parameter int OW    = 2,
    parameter int DW    = 16,
    parameter int BURST = 4
) (
    input  logic               clk,
    input  logic               rst,
    fifo_wr_arbiter_if.master  bus
`ifdef FIFO_WR_ARB_STAT_EN
    ,
    output logic [15:0]        stall_cnt
`endif
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [OW-1:0]     owner_q, owner_d;
    logic [OW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [7:0]        burst_cnt_q, burst_cnt_d;
    logic              fifo_we_q, fifo_we_d;
    logic [DW-1:0]     fifo_din_q, fifo_din_d;

    logic [OW-1:0]     sel;
    logic [OW-1:0]     owner_nxt;
    logic [DW-1:0]     owner_din;
    logic [NREQ-1:0]   gnt;
    logic              any_req;
    logic              space;
    logic              xfer;

    // The write register adds a cycle, so an almost-full fifo with a write in flight has no room.
    assign space     = !bus.fifo_full && !(bus.fifo_almost_full && fifo_we_q);
    assign xfer      = (state_q == S_BURST) && bus.req[owner_q] && space;
    assign any_req   = |bus.req;
    assign owner_din = bus.din[owner_q*DW +: DW];
    assign owner_nxt = (owner_q == OW'(NREQ-1)) ? '0 : owner_q + 1'b1;

    // Scanning offsets high to low lets the lowest offset from rr_ptr win.
    always_comb begin
        int            idx;
        logic [OW-1:0] idx_ow;
        sel    = rr_ptr_q;
        idx    = 0;
        idx_ow = '0;
        for (int k = NREQ-1; k >= 0; k--) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            idx_ow = OW'(idx);
            if (bus.req[idx_ow]) sel = idx_ow;
        end
    end

    always_comb begin
        gnt = '0;
        if (xfer) gnt[owner_q] = 1'b1;
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        fifo_we_d   = 1'b0;
        fifo_din_d  = fifo_din_q;
        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    owner_d     = sel;
                    burst_cnt_d = '0;
                    state_d     = S_BURST;
                end
            end
            S_BURST: begin
                if (xfer) begin
                    fifo_we_d   = 1'b1;
                    fifo_din_d  = owner_din;
                    burst_cnt_d = burst_cnt_q + 8'd1;
                    if (burst_cnt_q == 8'(BURST-1)) begin
                        state_d  = S_IDLE;
                        rr_ptr_d = owner_nxt;
                    end
                end else if (!bus.req[owner_q]) begin
                    state_d  = S_IDLE;
                    rr_ptr_d = owner_nxt;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
            fifo_we_q   <= 1'b0;
            fifo_din_q  <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
            fifo_we_q   <= fifo_we_d;
            fifo_din_q  <= fifo_din_d;
        end
    end

`ifdef FIFO_WR_ARB_STAT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((state_q == S_BURST) && bus.req[owner_q] && !space && (stall_cnt_q != 16'hFFFF))
            stall_cnt_d = stall_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) stall_cnt_q <= '0;
        else     stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
`endif

    assign bus.gnt      = gnt;
    assign bus.fifo_we  = fifo_we_q;
    assign bus.fifo_din = fifo_din_q;
    assign bus.busy     = (state_q == S_BURST);
    assign bus.owner    = owner_q;

endmodule
